// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider
// Each channel divides clk by its own ratio; ratio changes land on period boundaries only.
module clk_div_multi #(
   parameter int SELW        = 2,
   parameter int DIVW        = 16,
   parameter int DEFAULT_DIV = 2,
   localparam int NCH        = 2 ** SELW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NCH-1:0]  ch_en,
   input  logic            sync,
   input  logic            div_we,
   input  logic [SELW-1:0] div_sel,
   input  logic [DIVW-1:0] div_val,
   output logic [NCH-1:0]  clk_out,
   output logic [NCH-1:0]  tick,
   output logic [NCH-1:0]  applied
);

   logic [DIVW-1:0] act_q  [NCH];
   logic [DIVW-1:0] pend_q [NCH];
   logic [DIVW-1:0] cnt_q  [NCH];
   logic [NCH-1:0]  pv_q;
   logic [NCH-1:0]  run_q;

   logic [DIVW-1:0] act_d  [NCH];
   logic [DIVW-1:0] pend_d [NCH];
   logic [DIVW-1:0] cnt_d  [NCH];
   logic [NCH-1:0]  pv_d;
   logic [NCH-1:0]  run_d;
   logic [NCH-1:0]  lvl_d;
   logic [NCH-1:0]  tick_d;
   logic [NCH-1:0]  app_d;
   logic [NCH-1:0]  hit;

   function automatic logic [DIVW:0] half_of(input logic [DIVW-1:0] a);
      return ({1'b0, a} + (DIVW+1)'(1)) >> 1;
   endfunction

   always_comb begin
      hit = '0;
      for (int i = 0; i < NCH; i++) begin
         hit[i] = div_we && (div_sel == SELW'(i));
      end
   end

   always_comb begin
      pv_d   = pv_q;
      run_d  = run_q;
      lvl_d  = '0;
      tick_d = '0;
      app_d  = '0;
      for (int i = 0; i < NCH; i++) begin
         act_d[i]  = act_q[i];
         pend_d[i] = pend_q[i];
         cnt_d[i]  = cnt_q[i];
         // Restart point: disabled, sync, or idle -- writes and pending ratios land immediately.
         if (!ch_en[i] || sync || !run_q[i]) begin
            if (hit[i]) begin
               act_d[i] = div_val;
               app_d[i] = 1'b1;
            end else if (pv_q[i]) begin
               act_d[i] = pend_q[i];
               app_d[i] = 1'b1;
            end
            pv_d[i]  = 1'b0;
            cnt_d[i] = '0;
            if (ch_en[i] && (act_d[i] != '0)) begin
               run_d[i]  = 1'b1;
               tick_d[i] = 1'b1;
               lvl_d[i]  = (act_d[i] >= DIVW'(2));
            end else begin
               run_d[i] = 1'b0;
            end
         end else if (cnt_q[i] == act_q[i] - DIVW'(1)) begin
            // Wrap: commit the ratio pending before this edge; a write on this edge waits a period.
            if (pv_q[i]) begin
               act_d[i] = pend_q[i];
               app_d[i] = 1'b1;
            end
            pv_d[i]   = hit[i];
            pend_d[i] = hit[i] ? div_val : pend_q[i];
            cnt_d[i]  = '0;
            run_d[i]  = (act_d[i] != '0);
            tick_d[i] = (act_d[i] != '0);
            lvl_d[i]  = (act_d[i] >= DIVW'(2));
         end else begin
            cnt_d[i]  = cnt_q[i] + DIVW'(1);
            lvl_d[i]  = ({1'b0, cnt_d[i]} < half_of(act_q[i]));
            pv_d[i]   = pv_q[i] | hit[i];
            pend_d[i] = hit[i] ? div_val : pend_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NCH; i++) begin
            act_q[i]  <= DIVW'(DEFAULT_DIV);
            pend_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         pv_q    <= '0;
         run_q   <= '0;
         clk_out <= '0;
         tick    <= '0;
         applied <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            act_q[i]  <= act_d[i];
            pend_q[i] <= pend_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
         pv_q    <= pv_d;
         run_q   <= run_d;
         clk_out <= lvl_d;
         tick    <= tick_d;
         applied <= app_d;
      end
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - randomized bench for clk_div_multi against a period-level reference model
module tb_clk_div_multi;

   localparam int SELW = 2;
   localparam int DIVW = 16;
   localparam int DEF  = 2;
   localparam int NCH  = 4;

   logic            clk;
   logic            rst;
   logic [NCH-1:0]  ch_en;
   logic            sync;
   logic            div_we;
   logic [SELW-1:0] div_sel;
   logic [DIVW-1:0] div_val;
   logic [NCH-1:0]  clk_out;
   logic [NCH-1:0]  tick;
   logic [NCH-1:0]  applied;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: ratio, pending ratio, and position within the current period (-1 = parked).
   int m_a   [NCH];
   int m_p   [NCH];
   int m_pos [NCH];
   bit m_pv  [NCH];
   logic [NCH-1:0] e_clk, e_tick, e_app;

   clk_div_multi #(.SELW(SELW), .DIVW(DIVW), .DEFAULT_DIV(DEF)) dut (
      .clk     (clk),
      .rst     (rst),
      .ch_en   (ch_en),
      .sync    (sync),
      .div_we  (div_we),
      .div_sel (div_sel),
      .div_val (div_val),
      .clk_out (clk_out),
      .tick    (tick),
      .applied (applied)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < NCH; i++) begin
         bit h;
         h = div_we && (int'(div_sel) == i);
         e_tick[i] = 1'b0;
         e_clk[i]  = 1'b0;
         e_app[i]  = 1'b0;
         if (!rst) begin
            m_a[i] = DEF; m_pv[i] = 0; m_pos[i] = -1; m_p[i] = 0;
            continue;
         end
         if (!ch_en[i] || sync || m_pos[i] < 0) begin
            if (h) begin m_a[i] = int'(div_val); e_app[i] = 1'b1; end
            else if (m_pv[i]) begin m_a[i] = m_p[i]; e_app[i] = 1'b1; end
            m_pv[i]  = 0;
            m_pos[i] = (ch_en[i] && m_a[i] != 0) ? 0 : -1;
         end else if (m_pos[i] == m_a[i] - 1) begin
            if (m_pv[i]) begin m_a[i] = m_p[i]; e_app[i] = 1'b1; end
            m_pv[i] = h;
            if (h) m_p[i] = int'(div_val);
            m_pos[i] = (m_a[i] != 0) ? 0 : -1;
         end else begin
            m_pos[i]++;
            if (h) begin m_p[i] = int'(div_val); m_pv[i] = 1; end
         end
         if (m_pos[i] >= 0) begin
            e_tick[i] = (m_pos[i] == 0);
            e_clk[i]  = (m_a[i] >= 2) && (m_pos[i] < (m_a[i] + 1) / 2);
         end
      end
   endtask

   task automatic cyc(input logic r, input logic [NCH-1:0] en, input logic s,
                      input logic we, input int sel, input int val);
      @(negedge clk);
      rst     = r;
      ch_en   = en;
      sync    = s;
      div_we  = we;
      div_sel = SELW'(sel);
      div_val = DIVW'(val);
      model_step();
      @(posedge clk);
      #1;
      check("clk_out", 32'(clk_out), 32'(e_clk));
      check("tick",    32'(tick),    32'(e_tick));
      check("applied", 32'(applied), 32'(e_app));
   endtask

   initial begin
      logic [NCH-1:0] en_r;
      int v;
      rst = 1'b0; ch_en = '0; sync = 1'b0; div_we = 1'b0; div_sel = '0; div_val = '0;
      for (int i = 0; i < NCH; i++) begin m_a[i] = DEF; m_p[i] = 0; m_pos[i] = -1; m_pv[i] = 0; end

      repeat (2) cyc(0, 4'b0000, 0, 0, 0, 0);
      repeat (6) cyc(1, 4'b0001, 0, 0, 0, 0);
      cyc(1, 4'b0001, 0, 1, 1, 5);
      repeat (12) cyc(1, 4'b0011, 0, 0, 0, 0);
      cyc(1, 4'b0011, 0, 1, 0, 4);
      repeat (5) cyc(1, 4'b0011, 0, 0, 0, 0);
      cyc(1, 4'b0011, 0, 1, 0, 6);
      repeat (14) cyc(1, 4'b0011, 0, 0, 0, 0);
      cyc(1, 4'b0111, 0, 0, 0, 0);
      cyc(1, 4'b0111, 0, 1, 2, 3);
      cyc(1, 4'b0111, 0, 1, 2, 7);
      repeat (10) cyc(1, 4'b0111, 0, 0, 0, 0);
      cyc(1, 4'b0111, 1, 0, 0, 0);
      repeat (4) cyc(1, 4'b0111, 0, 0, 0, 0);
      cyc(1, 4'b0111, 0, 1, 3, 1);
      repeat (4) cyc(1, 4'b1111, 0, 0, 0, 0);
      cyc(1, 4'b1111, 0, 1, 3, 0);
      repeat (4) cyc(1, 4'b1111, 0, 0, 0, 0);
      cyc(1, 4'b1111, 0, 1, 3, 4);
      repeat (3) cyc(1, 4'b1111, 0, 0, 0, 0);
      cyc(0, 4'b1111, 0, 0, 0, 0);
      cyc(1, 4'b1111, 0, 0, 0, 0);

      en_r = 4'b1111;
      for (int k = 0; k < 4000; k++) begin
         for (int i = 0; i < NCH; i++)
            if ($urandom_range(0, 19) == 0) en_r[i] = ~en_r[i];
         case ($urandom_range(0, 15))
            0:       v = 0;
            1:       v = 1;
            2:       v = 65535;
            default: v = int'($urandom_range(2, 8));
         endcase
         cyc(($urandom_range(0, 299) != 0), en_r, ($urandom_range(0, 39) == 0),
             ($urandom_range(0, 3) == 0), int'($urandom_range(0, NCH - 1)), v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
